// File: rtl/fft_ram_ctrl_if.sv
// Control/address bundle between fft_ram_ctrl, the FFT top-level control and the 4-bank RAM/butterfly path.
interface fft_ram_ctrl_if #(
    parameter int A_BIT = 8,
    parameter int S_BIT = 3
);
    logic             iSTART;
    logic             oBUSY;
    logic             oDONE;
    logic [S_BIT-1:0] oSTAGE;
    logic [A_BIT-1:0] oADDR_RD;
    logic             oRD_VALID;
    logic [A_BIT-1:0] oBF_IDX;
    logic [A_BIT-1:0] oADDR_WR;
    logic             oWE;
    logic [S_BIT-1:0] oWR_STAGE;

    modport master (
        output iSTART,
        input  oBUSY, oDONE, oSTAGE, oADDR_RD, oRD_VALID, oBF_IDX,
        input  oADDR_WR, oWE, oWR_STAGE
    );

    modport slave (
        input  iSTART,
        output oBUSY, oDONE, oSTAGE, oADDR_RD, oRD_VALID, oBF_IDX,
        output oADDR_WR, oWE, oWR_STAGE
    );
endinterface

// File: rtl/fft_ram_ctrl.sv
// In-place radix-4 FFT RAM sequencer: per stage one shared read address per cycle, replayed as the write address LAT cycles later.
// Optional FFT_CTRL_DIGIT_REV_EN: final-stage writes go to the digit-reversed counter (natural-order output).
module fft_ram_ctrl #(
    parameter int A_BIT     = 8,
    parameter int STAGE_NUM = 5,
    parameter int S_BIT     = 3,
    parameter int LAT       = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    fft_ram_ctrl_if.slave bus
);
    localparam int               D          = A_BIT / 2;
    localparam logic [S_BIT-1:0] LAST_STAGE = S_BIT'(STAGE_NUM - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [A_BIT-1:0] cnt_q, cnt_d;
    logic [S_BIT-1:0] stage_q, stage_d;
    logic [3:0]       drain_q, drain_d;

    logic             rd_vld_q;
    logic             busy_q;
    logic             done_q;
    logic [A_BIT-1:0] addr_rd_q;
    logic [A_BIT-1:0] bf_idx_q;
    logic [A_BIT-1:0] wa_src;

    logic             dl_vld_q   [LAT];
    logic [A_BIT-1:0] dl_addr_q  [LAT];
    logic [S_BIT-1:0] dl_stage_q [LAT];

    // Rotate the counter left by (stage mod D) 2-bit digits.
    function automatic logic [A_BIT-1:0] rot_digits(input logic [A_BIT-1:0] c,
                                                    input logic [S_BIT-1:0] s);
        logic [A_BIT-1:0] r;
        int               n;
        r = c;
        n = int'(s) % D;
        for (int i = 0; i < D; i++) begin
            if (i < n) begin
                r = (r << 2) | (r >> (A_BIT - 2));
            end
        end
        return r;
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.iSTART) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        stage_d = stage_q + 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_rd_q <= '0;
            bf_idx_q  <= '0;
        end else begin
            rd_vld_q  <= (state_d == S_READ);
            busy_q    <= (state_d == S_READ) || (state_d == S_DRAIN);
            done_q    <= (state_d == S_DONE);
            addr_rd_q <= (state_d == S_READ) ? rot_digits(cnt_d, stage_d) : '0;
            bf_idx_q  <= (state_d == S_READ) ? cnt_d : '0;
        end
    end

`ifdef FFT_CTRL_DIGIT_REV_EN
    logic [A_BIT-1:0] wa_src_q;

    function automatic logic [A_BIT-1:0] rev_digits(input logic [A_BIT-1:0] c);
        logic [A_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[2*i +: 2] = c[2*(D-1-i) +: 2];
        end
        return r;
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wa_src_q <= '0;
        end else if (state_d != S_READ) begin
            wa_src_q <= '0;
        end else if (stage_d == LAST_STAGE) begin
            wa_src_q <= rev_digits(cnt_d);
        end else begin
            wa_src_q <= rot_digits(cnt_d, stage_d);
        end
    end

    assign wa_src = wa_src_q;
`else
    assign wa_src = addr_rd_q;
`endif

    // Write replay: reset flushes the line so an aborted transform stops writing at once.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < LAT; i++) begin
                dl_vld_q[i]   <= 1'b0;
                dl_addr_q[i]  <= '0;
                dl_stage_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0]   <= rd_vld_q;
            dl_addr_q[0]  <= wa_src;
            dl_stage_q[0] <= rd_vld_q ? stage_q : '0;
            for (int i = 1; i < LAT; i++) begin
                dl_vld_q[i]   <= dl_vld_q[i-1];
                dl_addr_q[i]  <= dl_addr_q[i-1];
                dl_stage_q[i] <= dl_stage_q[i-1];
            end
        end
    end

    assign bus.oBUSY     = busy_q;
    assign bus.oDONE     = done_q;
    assign bus.oSTAGE    = stage_q;
    assign bus.oADDR_RD  = addr_rd_q;
    assign bus.oRD_VALID = rd_vld_q;
    assign bus.oBF_IDX   = bf_idx_q;
    assign bus.oADDR_WR  = dl_addr_q[LAT-1];
    assign bus.oWE       = dl_vld_q[LAT-1];
    assign bus.oWR_STAGE = dl_stage_q[LAT-1];
endmodule

// File: tb/tb_fft_ram_ctrl.sv
// Scoreboard bench for fft_ram_ctrl: transform-level reference model feeds expectation queues, a negedge monitor pops and compares.
module tb_fft_ram_ctrl;
    localparam int A_BIT     = 4;
    localparam int STAGE_NUM = 3;
    localparam int S_BIT     = 2;
    localparam int LAT       = 3;
    localparam int N         = 1 << A_BIT;
    localparam int D         = A_BIT / 2;
    localparam int PERIOD    = N + LAT;
    localparam int RUN_LEN   = STAGE_NUM * PERIOD;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    fft_ram_ctrl_if #(.A_BIT(A_BIT), .S_BIT(S_BIT)) bus ();

    fft_ram_ctrl #(
        .A_BIT(A_BIT), .STAGE_NUM(STAGE_NUM), .S_BIT(S_BIT), .LAT(LAT)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int edge_i;
        int addr;
        int bf;
        int stage;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   done_q[$];
    exp_t me;

    int ecnt      = 0;
    int busy_lo   = 1;
    int busy_hi   = 0;
    int idle_from = 0;
    int hits [STAGE_NUM][N];
    int nchk = 0;
    int nerr = 0;

    always @(posedge iCLK) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        nchk++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, ecnt);
        end
    endtask

    // Rotation left by r digits written as plain arithmetic on the digit string.
    function automatic int rot_ref(input int c, input int s);
        int p;
        p = 4 ** (s % D);
        return ((c * p) % N) + (c / (N / p));
    endfunction

    function automatic int rev_ref(input int c);
        int x, r;
        x = c;
        r = 0;
        for (int i = 0; i < D; i++) begin
            r = r * 4 + x % 4;
            x = x / 4;
        end
        return r;
    endfunction

    task automatic push_run(input int e0);
        exp_t r, w;
        for (int s = 0; s < STAGE_NUM; s++) begin
            for (int c = 0; c < N; c++) begin
                r.edge_i = e0 + s * PERIOD + c;
                r.addr   = rot_ref(c, s);
                r.bf     = c;
                r.stage  = s;
                rd_q.push_back(r);
                w        = r;
                w.edge_i = r.edge_i + LAT;
`ifdef FFT_CTRL_DIGIT_REV_EN
                if (s == STAGE_NUM - 1) w.addr = rev_ref(c);
`endif
                wr_q.push_back(w);
            end
        end
        done_q.push_back(e0 + RUN_LEN);
        busy_lo   = e0;
        busy_hi   = e0 + RUN_LEN - 1;
        idle_from = e0 + RUN_LEN + 2;
    endtask

    always @(negedge iCLK) begin
        if (!iRST) begin
            chk("busy", int'(bus.oBUSY), int'(ecnt >= busy_lo && ecnt <= busy_hi));
            if (bus.oRD_VALID) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", int'(bus.oRD_VALID), 0);
                end else begin
                    me = rd_q.pop_front();
                    chk("rd_edge", ecnt, me.edge_i);
                    chk("rd_addr", int'(bus.oADDR_RD), me.addr);
                    chk("rd_bf", int'(bus.oBF_IDX), me.bf);
                    chk("rd_stage", int'(bus.oSTAGE), me.stage);
                end
            end
            if (bus.oWE) begin
                if (int'(bus.oWR_STAGE) < STAGE_NUM)
                    hits[bus.oWR_STAGE][bus.oADDR_WR] += 1;
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", int'(bus.oWE), 0);
                end else begin
                    me = wr_q.pop_front();
                    chk("wr_edge", ecnt, me.edge_i);
                    chk("wr_addr", int'(bus.oADDR_WR), me.addr);
                    chk("wr_stage", int'(bus.oWR_STAGE), me.stage);
                end
            end
            if (bus.oDONE) begin
                if (done_q.size() == 0) chk("done_unexpected", int'(bus.oDONE), 0);
                else chk("done_edge", ecnt, done_q.pop_front());
            end
        end
    end

    task automatic wait_neg(input int target);
        do @(negedge iCLK); while (ecnt < target);
    endtask

    // Pulse iSTART for one edge; the model decides acceptance from its own timeline.
    task automatic issue_start(output int acc);
        bus.iSTART = 1'b1;
        @(posedge iCLK);
        #1;
        acc = ecnt;
        bus.iSTART = 1'b0;
        if (acc >= idle_from) push_run(acc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   int'(bus.oBUSY), 0);
        chk({tag, "_done"},   int'(bus.oDONE), 0);
        chk({tag, "_stage"},  int'(bus.oSTAGE), 0);
        chk({tag, "_addrrd"}, int'(bus.oADDR_RD), 0);
        chk({tag, "_rdvld"},  int'(bus.oRD_VALID), 0);
        chk({tag, "_bf"},     int'(bus.oBF_IDX), 0);
        chk({tag, "_addrwr"}, int'(bus.oADDR_WR), 0);
        chk({tag, "_we"},     int'(bus.oWE), 0);
        chk({tag, "_wrstg"},  int'(bus.oWR_STAGE), 0);
    endtask

    task automatic clear_hits();
        for (int s = 0; s < STAGE_NUM; s++)
            for (int a = 0; a < N; a++) hits[s][a] = 0;
    endtask

    task automatic check_hits();
        int bad;
        for (int s = 0; s < STAGE_NUM; s++) begin
            bad = 0;
            for (int a = 0; a < N; a++) if (hits[s][a] != 1) bad++;
            chk("wr_once", bad, 0);
        end
        clear_hits();
    endtask

    task automatic wait_drained();
        int guard = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) && guard < 300) begin
            @(negedge iCLK);
            guard++;
        end
        chk("left_rd", rd_q.size(), 0);
        chk("left_wr", wr_q.size(), 0);
        chk("left_done", done_q.size(), 0);
        @(negedge iCLK);
    endtask

    initial begin
        int e0, e1, acc, k1, k2, k3;
        bus.iSTART = 1'b0;
        clear_hits();
        #12;
        check_zero("reset");
        @(negedge iCLK);
        iRST = 1'b0;

        // Run 1 with ignored starts in cycles 10 and 58, restart in cycle 59.
        repeat ($urandom_range(1, 4)) @(negedge iCLK);
        issue_start(e0);
        wait_neg(e0 + 9);
        issue_start(acc);
        wait_neg(e0 + 57);
        issue_start(acc);
        issue_start(e1);
        chk("restart_edge", e1, e0 + RUN_LEN + 2);
        check_hits();

        // Run 2 aborted by reset in the middle of cycle 25.
        wait_neg(e1 + 24);
        #2;
        iRST = 1'b1;
        #1;
        check_zero("abort");
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_lo   = 1;
        busy_hi   = 0;
        idle_from = 0;
        clear_hits();
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        repeat (20) @(negedge iCLK);

        // Randomised runs with spurious starts while busy.
        for (int run = 0; run < 2; run++) begin
            repeat ($urandom_range(1, 6)) @(negedge iCLK);
            issue_start(e0);
            k1 = $urandom_range(2, 20);
            k2 = $urandom_range(21, 40);
            k3 = $urandom_range(41, 58);
            wait_neg(e0 + k1 - 1);
            issue_start(acc);
            wait_neg(e0 + k2 - 1);
            issue_start(acc);
            wait_neg(e0 + k3 - 1);
            issue_start(acc);
            wait_drained();
            check_hits();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fft_ram_ctrl.md
Name: fft_ram_ctrl

Overview:
- Sequencer for the 4-bank FFT RAM block: runs all radix-4 stages of one in-place transform.
- Per stage, issues one shared read address per cycle to all four banks and produces the butterfly index for twiddle lookup.
- Replays each read address as the write address after the fixed butterfly pipeline latency, with write enable for all banks.
- Sits between the top-level FFT control (start/done) and the RAM block / butterfly datapath.

Parameters:
- A_BIT, 8, bank address width; must be even; butterflies per stage = 2^A_BIT; D = A_BIT/2 digits.
- STAGE_NUM, 5, number of radix-4 stages (normally D+1).
- S_BIT, 3, width of stage outputs; 2^S_BIT >= STAGE_NUM.
- LAT, 4, cycles from oADDR_RD valid to matching oADDR_WR/oWE; legal range 2..15.

Ports:
- iCLK  in  1  clock, all logic on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iSTART  in  1  start request; sampled only in IDLE.
- oBUSY  out  1  high from the cycle after start acceptance until oDONE.
- oDONE  out  1  one-cycle pulse after the last write of the last stage.
- oSTAGE  out  S_BIT  stage currently issuing reads.
- oADDR_RD  out  A_BIT  read address, common to RAM ports 0..3.
- oRD_VALID  out  1  oADDR_RD / oBF_IDX valid this cycle.
- oBF_IDX  out  A_BIT  raw butterfly counter, for twiddle ROM.
- oADDR_WR  out  A_BIT  write address, common to RAM ports 0..3.
- oWE  out  1  write enable, fanned to iWE_0..3.
- oWR_STAGE  out  S_BIT  stage of the current write.

Behaviour:
- Reset (async): state IDLE; all outputs 0; counter, stage and delay line cleared.
- Reset mid-transform aborts immediately: no further oWE, no oDONE.
- All outputs are registered.
- States and transitions:
  - IDLE -> READ when iSTART=1 at an edge; stage=0, cnt=0.
  - READ: oRD_VALID=1 each cycle; cnt increments; on cnt=2^A_BIT-1 the next state is DRAIN.
  - DRAIN: oRD_VALID=0; lasts exactly LAT cycles.
    - Last cycle, non-final stage: next state READ with stage+1, cnt=0.
    - Last cycle, final stage: next state DONE.
  - DONE: oDONE=1 and oBUSY=0 for one cycle, then IDLE.
- Timing: iSTART seen at edge E0 -> first read in cycle 1 (outputs after E0+1). oBUSY rises in cycle 1.
- Stage period = 2^A_BIT + LAT cycles, so stage k first read is at cycle 1 + k*(2^A_BIT+LAT). No overlap of stages, so there is no read-before-write hazard.
- Last write of a stage precedes the next stage's first read by exactly 1 cycle.
- Address mapping: cnt split into D 2-bit digits. oADDR_RD = cnt digit-rotated left by (stage mod D) digits. oBF_IDX = cnt.
- Write path: LAT-deep shift register carries {valid, address, stage}. oWE / oADDR_WR / oWR_STAGE equal oRD_VALID / oADDR_RD / oSTAGE delayed LAT cycles.
- iSTART while busy or in DONE is ignored and not queued.

Optional Feature:
- Macro: FFT_CTRL_DIGIT_REV_EN.
- Defined: during the final stage only, oADDR_WR = cnt with its D digits reversed, giving natural-order output. Delay line carries the reversed address; reads unchanged.
- Undefined: write address is always the delayed read address (pure in-place).

Test Plan:
- A_BIT=4, STAGE_NUM=3, LAT=3, iSTART at E0 -> reads cycles 1-16, 20-35, 39-54. oWE cycles 4-19, 23-38, 42-57. oDONE single pulse cycle 58. oBUSY 1..57.
- Same config, stage 1, cnt=1 -> oADDR_RD=4; cnt=6 -> 9. Stage 2, cnt=6 -> oADDR_RD=6 (rotation 0).
- With FFT_CTRL_DIGIT_REV_EN: final-stage write for cnt=1 -> oADDR_WR=4; cnt=6 -> 9. Stages 0-1 writes unchanged.
- iSTART pulsed at cycles 10 and 58 -> ignored (no restart, no extra oDONE). iSTART at cycle 59 -> new transform, first read cycle 60.
- iRST asserted asynchronously mid-cycle 25 -> all outputs 0 immediately; no oWE afterwards. Next iSTART restarts at stage 0, cnt 0.
- Every write (address, stage) equals the read issued LAT cycles earlier. Over all runs, each address is written exactly once per stage.
